key_debounce: RTL

Input-conditioning stage that sits directly upstream of the VGA display top and drives its 8-bit `key` (note) vector. It takes the eight raw, asynchronous keyboard buttons, synchronises and debounces each one, and presents a clean level vector. It also produces per-key press/release strobes and a registered "last pressed note" index for the audio and display stages.

---
 rtl/key_pkg.sv | 14 +
 rtl/key_debounce_cell.sv | 58 +++++
 rtl/key_debounce.sv | 39 +++
 3 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared types and constants for the keyboard debounce stage.
package key_pkg;
  typedef enum logic [1:0] {LOW, WAIT_HI, HIGH, WAIT_LO} db_state_t;
  localparam int NUM_KEYS = 8;
  localparam int NOTE_W = 3;
  localparam int DEFAULT_DEBOUNCE = 2_000_000;
  // Lowest set bit wins when several keys are accepted in the same cycle.
  function automatic logic [NOTE_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    logic [NOTE_W-1:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) if (v[i]) r = NOTE_W'(i);
    return r;
  endfunction
endpackage

// File: rtl/key_debounce_cell.sv
// key_debounce_cell: one key's two-flop synchroniser, debounce FSM and counter.
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_nxt
);
  logic [1:0] r_sync;
  db_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic w_s, w_done, w_level_nxt, w_fall_nxt;
  assign w_s = r_sync[1];
  assign w_done = r_cnt == CNT_W'(DEBOUNCE_CYCLES - 2);
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync  <= '0;
      r_state <= LOW;
      r_cnt   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], key_raw};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      level   <= w_level_nxt;
      rise    <= rise_nxt;
      fall    <= w_fall_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      LOW:     if (w_s) begin w_state_nxt = WAIT_HI; w_cnt_nxt = '0; end
      HIGH:    if (!w_s) begin w_state_nxt = WAIT_LO; w_cnt_nxt = '0; end
      WAIT_HI: if (!w_s) begin w_state_nxt = LOW; w_cnt_nxt = '0; end
               else if (w_done) w_state_nxt = HIGH;
               else w_cnt_nxt = r_cnt + 1'b1;
      WAIT_LO: if (w_s) begin w_state_nxt = HIGH; w_cnt_nxt = '0; end
               else if (w_done) w_state_nxt = LOW;
               else w_cnt_nxt = r_cnt + 1'b1;
    endcase
  end
  always_comb begin
    w_level_nxt = (w_state_nxt == HIGH) || (w_state_nxt == WAIT_LO);
    rise_nxt = (r_state == WAIT_HI) && w_s && w_done;
    w_fall_nxt = (r_state == WAIT_LO) && !w_s && w_done;
  end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: eight debounced keys with press/release strobes and last-pressed note index.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic                note_valid,
  output logic [NOTE_W-1:0]   note_idx
);
  logic [NUM_KEYS-1:0] w_rise_nxt;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_cell
    key_debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_cell (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .key_raw (key_raw[k]),
      .level   (key[k]),
      .rise    (press_pulse[k]),
      .fall    (release_pulse[k]),
      .rise_nxt(w_rise_nxt[k])
    );
  end
  // Fed from the cells' next-cycle rise so the index lands with the press strobe.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      note_valid <= 1'b0;
      note_idx   <= '0;
    end else begin
      note_valid <= |w_rise_nxt;
      note_idx   <= |w_rise_nxt ? lowest_idx(w_rise_nxt) : note_idx;
    end
  end
endmodule
